// File: rtl/usart_pkg.sv
// Shared USART definitions for the TX/RX framers and the parity engine.
// Holds the parity-mode encodings and a helper that tells whether a mode
// carries a parity bit that should be checked.
package usart_pkg;

  localparam int unsigned ModeW = 3;

  typedef enum logic [ModeW-1:0] {
    ModeNone  = 3'd0,
    ModeEven  = 3'd1,
    ModeOdd   = 3'd2,
    ModeMark  = 3'd3,
    ModeSpace = 3'd4
  } parity_mode_e;

  // Reserved encodings 5..7 behave as NONE, so they are not checked.
  function automatic logic mode_checked(logic [ModeW-1:0] mode);
    logic checked;
    case (mode)
      ModeEven, ModeOdd, ModeMark, ModeSpace: checked = 1'b1;
      default:                                checked = 1'b0;
    endcase
    return checked;
  endfunction

endpackage

// File: rtl/usart_parity_calc.sv
// Combinational parity generator.
// Ports:
//   data : data word (DATA_W bits)
//   mode : parity mode (usart_pkg encodings; reserved values act as NONE)
//   par  : computed parity bit
module usart_parity_calc
  import usart_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  input  logic [ModeW-1:0]  mode,
  output logic              par
);

  always_comb begin
    par = 1'b0;
    case (mode)
      ModeEven: par = ^data;
      ModeOdd:  par = ~^data;
      ModeMark: par = 1'b1;
      default:  par = 1'b0;
    endcase
  end

endmodule

// File: rtl/usart_parity_engine.sv
// One-entry parity pipeline stage: generates the parity bit for a word,
// flags a mismatch against the received parity, and keeps a saturating
// mismatch count.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   cfg_mode          : parity mode, sampled at acceptance
//   in_valid/in_ready : input handshake; in_data, in_par are the word and rx parity
//   out_valid/out_ready : output handshake; out_par, out_err are the held result
//   err_cnt, err_cnt_clr : saturating mismatch counter and its clear
module usart_parity_engine
  import usart_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ModeW-1:0]  cfg_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_par,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_par,
  output logic              out_err,
  output logic [CNT_W-1:0]  err_cnt,
  input  logic              err_cnt_clr
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e           state_q;
  logic             out_par_q;
  logic             out_err_q;
  logic [CNT_W-1:0] err_cnt_q;

  logic calc_par;
  logic calc_err;
  logic accept;
  logic err_accept;

  usart_parity_calc #(
    .DATA_W(DATA_W)
  ) u_calc (
    .data(in_data),
    .mode(cfg_mode),
    .par (calc_par)
  );

  assign calc_err   = mode_checked(cfg_mode) && (in_par != calc_par);
  assign out_valid  = (state_q == StFull);
  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign err_accept = accept && calc_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StEmpty;
      out_par_q <= 1'b0;
      out_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_q   <= StFull;
            out_par_q <= calc_par;
            out_err_q <= calc_err;
          end
        end
        StFull: begin
          if (accept) begin
            // Consume and reload in the same cycle.
            out_par_q <= calc_par;
            out_err_q <= calc_err;
          end else if (out_ready) begin
            state_q <= StEmpty;
          end
        end
        default: state_q <= StEmpty;
      endcase

      // Clear wins over the old count, but a coincident error still counts.
      if (err_cnt_clr) begin
        err_cnt_q <= err_accept ? CNT_W'(1) : '0;
      end else if (err_accept && !(&err_cnt_q)) begin
        err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
    end
  end

  assign out_par = out_par_q;
  assign out_err = out_err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_usart_parity_engine.sv
module tb_usart_parity_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] cfg_mode;
  logic       in_par;
  logic       out_ready;
  logic       err_cnt_clr;
  logic [7:0] in_data;
  logic [4:0] in_data5;
  logic       v8, v2, v5;

  logic       r8, ov8, op8, oe8;
  logic [7:0] ec8;
  logic       r2, ov2, op2, oe2;
  logic [1:0] ec2;
  logic       r5, ov5, op5, oe5;
  logic [7:0] ec5;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  usart_parity_engine #(.DATA_W(8), .CNT_W(8)) u8 (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .in_valid(v8), .in_ready(r8),
    .in_data(in_data), .in_par(in_par), .out_valid(ov8), .out_ready(out_ready),
    .out_par(op8), .out_err(oe8), .err_cnt(ec8), .err_cnt_clr(err_cnt_clr)
  );

  usart_parity_engine #(.DATA_W(8), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .in_valid(v2), .in_ready(r2),
    .in_data(in_data), .in_par(in_par), .out_valid(ov2), .out_ready(out_ready),
    .out_par(op2), .out_err(oe2), .err_cnt(ec2), .err_cnt_clr(err_cnt_clr)
  );

  usart_parity_engine #(.DATA_W(5), .CNT_W(8)) u5 (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .in_valid(v5), .in_ready(r5),
    .in_data(in_data5), .in_par(in_par), .out_valid(ov5), .out_ready(out_ready),
    .out_par(op5), .out_err(oe5), .err_cnt(ec5), .err_cnt_clr(err_cnt_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    v8 = 1'b0; v2 = 1'b0; v5 = 1'b0;
    err_cnt_clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [2:0] mode;
    logic [7:0] data;
    logic       par;
    logic       exp_par;
    logic       exp_err;
  } vec_t;

  vec_t vecs[12];
  int   exp_cnt;
  logic [1:0] sat_exp[5];

  initial begin
    vecs[0]  = '{3'd1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'd2, 8'h01, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{3'd2, 8'h03, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{3'd1, 8'h07, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{3'd3, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{3'd4, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{3'd4, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{3'd0, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{3'd6, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{3'd5, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{3'd7, 8'h7F, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{3'd2, 8'hFF, 1'b1, 1'b1, 1'b0};
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    rst = 1'b1; cfg_mode = 3'd1; in_par = 1'b1; out_ready = 1'b1;
    err_cnt_clr = 1'b0; in_data = 8'hFF; in_data5 = 5'h1F;
    v8 = 1'b0; v2 = 1'b0; v5 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // Junk inputs with in_valid low must not load anything.
    @(negedge clk);
    chk("rst_out_valid", {31'd0, ov8}, 32'd0);
    chk("rst_out_par", {31'd0, op8}, 32'd0);
    chk("rst_out_err", {31'd0, oe8}, 32'd0);
    chk("rst_err_cnt", {24'd0, ec8}, 32'd0);
    chk("rst_in_ready", {29'd0, r8, r2, r5}, 32'd7);
    chk("rst_out_valid_others", {30'd0, ov2, ov5}, 32'd0);

    // Table of single words, one accept then one check.
    exp_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      cfg_mode = vecs[i].mode; in_data = vecs[i].data; in_par = vecs[i].par;
      out_ready = 1'b1; v8 = 1'b1;
      @(negedge clk);
      v8 = 1'b0;
      cfg_mode = 3'd3; // changing mode after acceptance must not matter
      if (vecs[i].exp_err && exp_cnt < 255) exp_cnt++;
      chk($sformatf("vec%0d_out_valid", i), {31'd0, ov8}, 32'd1);
      chk($sformatf("vec%0d_out_par", i), {31'd0, op8}, {31'd0, vecs[i].exp_par});
      chk($sformatf("vec%0d_out_err", i), {31'd0, oe8}, {31'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_err_cnt", i), {24'd0, ec8}, exp_cnt);
    end

    // Backpressure: hold a word while the next one waits with mode changing.
    @(negedge clk);
    @(negedge clk);
    chk("bp_empty", {31'd0, ov8}, 32'd0);
    cfg_mode = 3'd1; in_data = 8'h01; in_par = 1'b0; out_ready = 1'b0; v8 = 1'b1;
    @(negedge clk);
    exp_cnt++;
    chk("bp_first_par", {31'd0, op8}, 32'd1);
    chk("bp_first_err", {31'd0, oe8}, 32'd1);
    chk("bp_first_cnt", {24'd0, ec8}, exp_cnt);
    chk("bp_ready_low", {31'd0, r8}, 32'd0);
    cfg_mode = 3'd2; in_data = 8'h03; in_par = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp_stall%0d_ready", k), {31'd0, r8}, 32'd0);
      chk($sformatf("bp_stall%0d_hold", k), {30'd0, ov8, op8}, 32'd3);
      chk($sformatf("bp_stall%0d_err", k), {31'd0, oe8}, 32'd1);
      chk($sformatf("bp_stall%0d_cnt", k), {24'd0, ec8}, exp_cnt);
      cfg_mode = (k == 0) ? 3'd4 : ((k == 1) ? 3'd3 : 3'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ready_comb", {31'd0, r8}, 32'd1);
    @(negedge clk);
    v8 = 1'b0;
    chk("bp_second_valid", {31'd0, ov8}, 32'd1);
    chk("bp_second_par", {31'd0, op8}, 32'd0);
    chk("bp_second_err", {31'd0, oe8}, 32'd0);
    chk("bp_second_cnt", {24'd0, ec8}, exp_cnt);

    // Reset while FULL with err_cnt=2.
    do_reset();
    chk("rst2_cnt", {24'd0, ec8}, 32'd0);
    cfg_mode = 3'd3; in_data = 8'h55; in_par = 1'b0; out_ready = 1'b1; v8 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0; v8 = 1'b0;
    chk("pre_rst_full", {31'd0, ov8}, 32'd1);
    chk("pre_rst_cnt", {24'd0, ec8}, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", {31'd0, ov8}, 32'd0);
    chk("mid_rst_cnt", {24'd0, ec8}, 32'd0);
    chk("mid_rst_ready", {31'd0, r8}, 32'd1);
    chk("mid_rst_par_err", {30'd0, op8, oe8}, 32'd0);
    @(negedge clk);
    chk("post_rst_valid", {31'd0, ov8}, 32'd0);

    // Saturation with CNT_W=2, then clear with/without coincident error.
    do_reset();
    out_ready = 1'b1;
    cfg_mode = 3'd3; in_data = 8'h12; in_par = 1'b0; v2 = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk($sformatf("sat%0d_cnt", j), {30'd0, ec2}, {30'd0, sat_exp[j]});
      chk($sformatf("sat%0d_par_err", j), {30'd0, op2, oe2}, 32'd3);
    end
    err_cnt_clr = 1'b1;
    @(negedge clk);
    chk("clr_with_err", {30'd0, ec2}, 32'd1);
    v2 = 1'b0;
    @(negedge clk);
    chk("clr_alone", {30'd0, ec2}, 32'd0);
    err_cnt_clr = 1'b0;

    // DATA_W=5 instance.
    do_reset();
    out_ready = 1'b1;
    cfg_mode = 3'd1; in_data5 = 5'h1F; in_par = 1'b1; v5 = 1'b1;
    @(negedge clk);
    chk("w5_1f_par", {30'd0, ov5, op5}, 32'd3);
    chk("w5_1f_err", {31'd0, oe5}, 32'd0);
    in_data5 = 5'h03; in_par = 1'b0;
    @(negedge clk);
    chk("w5_03_par_err", {30'd0, op5, oe5}, 32'd0);
    cfg_mode = 3'd2; in_data5 = 5'h10; in_par = 1'b1;
    @(negedge clk);
    v5 = 1'b0;
    chk("w5_10_par_err", {30'd0, op5, oe5}, 32'd1);
    chk("w5_cnt", {24'd0, ec5}, 32'd1);
    chk("w5_ready", {31'd0, r5}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
